// File: rtl/int_op_sequencer_pkg.sv
// ============================================================================
// Module      : int_op_sequencer_pkg
// Description : Opcode constants shared with the decode stage, the sequencer
//               state encoding, and the helper that maps a sequencer state to
//               the opcode/control word driven into the fetch/decode buffer.
// Config      : no macros used in this file (INT_PEND_LATCH_EN lives in the
//               sequencer itself).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package int_op_sequencer_pkg;

  // Opcode values (5-bit encoding understood by the decode stage)
  localparam logic [4:0] c_op_nop      = 5'b00000;
  localparam logic [4:0] c_op_ldm      = 5'b10010;
  localparam logic [4:0] c_op_ret      = 5'b11101;
  localparam logic [4:0] c_op_rti      = 5'b11110;
  localparam logic [4:0] c_op_push_flg = 5'b11111;
  localparam logic [4:0] c_op_push_pcl = 5'b10101;
  localparam logic [4:0] c_op_push_pch = 5'b10110;
  localparam logic [4:0] c_op_pop_pcl  = 5'b10111;
  localparam logic [4:0] c_op_pop_flg  = 5'b01111;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    DRAIN    = 4'd1,
    PUSH_FLG = 4'd2,
    PUSH_PCL = 4'd3,
    PUSH_PCH = 4'd4,
    VEC      = 4'd5,
    RET_POPL = 4'd6,
    RTI_POPL = 4'd7,
    RTI_POPF = 4'd8,
    RWAIT    = 4'd9
  } seq_state_e;

  typedef struct packed {
    logic       inj_valid;
    logic [4:0] inj_op;
    logic       pc_hold;
    logic       load_vector;
    logic       int_ack;
    logic       busy;
  } seq_out_t;

  // Output word presented while the sequencer sits in state s. The LDM
  // slot is the one DRAIN cycle that lets the immediate word through
  // untouched, so it injects nothing and does not hold the PC.
  function automatic seq_out_t seq_outputs(input seq_state_e s, input logic ldm_extra);
    seq_out_t o;
    o      = '0;
    o.busy = (s != IDLE);
    case (s)
      DRAIN: begin
        if (!ldm_extra) begin
          o.inj_valid = 1'b1;
          o.inj_op    = c_op_nop;
          o.pc_hold   = 1'b1;
        end
      end
      PUSH_FLG: begin
        o.inj_valid = 1'b1;
        o.inj_op    = c_op_push_flg;
        o.pc_hold   = 1'b1;
      end
      PUSH_PCL: begin
        o.inj_valid = 1'b1;
        o.inj_op    = c_op_push_pcl;
        o.pc_hold   = 1'b1;
      end
      PUSH_PCH: begin
        o.inj_valid = 1'b1;
        o.inj_op    = c_op_push_pch;
        o.pc_hold   = 1'b1;
      end
      VEC: begin
        o.inj_valid   = 1'b1;
        o.inj_op      = c_op_nop;
        o.pc_hold     = 1'b1;
        o.load_vector = 1'b1;
        o.int_ack     = 1'b1;
      end
      RET_POPL, RTI_POPL: begin
        o.inj_valid = 1'b1;
        o.inj_op    = c_op_pop_pcl;
        o.pc_hold   = 1'b1;
      end
      RTI_POPF: begin
        o.inj_valid = 1'b1;
        o.inj_op    = c_op_pop_flg;
        o.pc_hold   = 1'b1;
      end
      RWAIT: begin
        o.inj_valid = 1'b1;
        o.inj_op    = c_op_nop;
        o.pc_hold   = 1'b1;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

`default_nettype wire

// File: rtl/int_op_sequencer_if.sv
// ============================================================================
// Module      : int_op_sequencer_if
// Description : Handshake bundle between fetch, the opcode sequencer and the
//               fetch/decode buffer.
//   master modport (sequencer side):
//     in : int_req, fetched_op[OP_W], fetched_valid, stall
//     out: inj_valid, inj_op[OP_W], pc_hold, load_vector, int_ack,
//          int_dropped, busy
//   slave modport: the same signals with directions reversed.
// Config      : no macros used in this file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface int_op_sequencer_if #(
  parameter int OP_W = 5
);
  logic            int_req;
  logic [OP_W-1:0] fetched_op;
  logic            fetched_valid;
  logic            stall;
  logic            inj_valid;
  logic [OP_W-1:0] inj_op;
  logic            pc_hold;
  logic            load_vector;
  logic            int_ack;
  logic            int_dropped;
  logic            busy;

  modport master (
    input  int_req, fetched_op, fetched_valid, stall,
    output inj_valid, inj_op, pc_hold, load_vector, int_ack, int_dropped, busy
  );

  modport slave (
    output int_req, fetched_op, fetched_valid, stall,
    input  inj_valid, inj_op, pc_hold, load_vector, int_ack, int_dropped, busy
  );
endinterface

`default_nettype wire

// File: rtl/int_op_sequencer.sv
// ============================================================================
// Module      : int_op_sequencer
// Description : Producer of the special micro-op stream for interrupt entry
//               (drain, push FLG/PCL/PCH, vector load) and RET/RTI completion
//               (pops followed by a drain). While a sequence runs the fetched
//               opcode is overridden and the PC increment is held.
// Ports       : clk, reset (asynchronous, active-high)
//               bus (int_op_sequencer_if.master): int_req, fetched_op,
//               fetched_valid, stall in; inj_valid, inj_op, pc_hold,
//               load_vector, int_ack, int_dropped, busy out.
// Parameters  : OP_W (opcode width), DRAIN_CYCLES (NOP slots around the
//               interrupt pushes and after the return pops).
// Config      : INT_PEND_LATCH_EN - when defined, a request that arrives while
//               busy (or together with RET/RTI) is latched and serviced from
//               IDLE afterwards; otherwise it is discarded with int_dropped.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module int_op_sequencer
  import int_op_sequencer_pkg::*;
#(
  parameter int OP_W         = 5,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  int_op_sequencer_if.master  bus
);

  localparam int              CNT_W   = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] c_drain = CNT_W'(DRAIN_CYCLES);
  localparam logic [CNT_W-1:0] c_one   = CNT_W'(1);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ldm_q, ldm_d;
  logic             pending_q, pending_d;
  logic             dropped_q, dropped_d;
  seq_out_t         out_q;

  logic w_ret_hit;
  logic w_rti_hit;
  logic w_is_ldm;
  logic w_req_busy;

  assign w_ret_hit = (state_q == IDLE) && bus.fetched_valid && (bus.fetched_op == OP_W'(c_op_ret));
  assign w_rti_hit = (state_q == IDLE) && bus.fetched_valid && (bus.fetched_op == OP_W'(c_op_rti));
  assign w_is_ldm  = (bus.fetched_op == OP_W'(c_op_ldm));

  // A request cannot start a sequence if the sequencer is frozen, already
  // running (VEC included), or a return sequence wins priority this cycle.
  assign w_req_busy = bus.int_req &&
                      (bus.stall || (state_q != IDLE) || w_ret_hit || w_rti_hit);

  // Next-state / counter logic; only committed when stall is low.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ldm_d   = ldm_q;
    case (state_q)
      IDLE: begin
        if (w_ret_hit) begin
          state_d = RET_POPL;
        end else if (w_rti_hit) begin
          state_d = RTI_POPL;
        end else if (bus.int_req || pending_q) begin
          ldm_d = w_is_ldm;
          cnt_d = c_drain;
          // With no drain slots and no LDM gap there is nothing to wait for.
          if (w_is_ldm || (DRAIN_CYCLES != 0)) state_d = DRAIN;
          else                                 state_d = PUSH_FLG;
        end
      end
      DRAIN: begin
        if (ldm_q) begin
          ldm_d = 1'b0;
          if (cnt_q == '0) state_d = PUSH_FLG;
        end else begin
          cnt_d = cnt_q - c_one;
          if (cnt_q <= c_one) state_d = PUSH_FLG;
        end
      end
      PUSH_FLG: state_d = PUSH_PCL;
      PUSH_PCL: state_d = PUSH_PCH;
      PUSH_PCH: state_d = VEC;
      VEC:      state_d = IDLE;
      RTI_POPL: state_d = RTI_POPF;
      RET_POPL, RTI_POPF: begin
        cnt_d = c_drain;
        if (DRAIN_CYCLES != 0) state_d = RWAIT;
        else                   state_d = IDLE;
      end
      RWAIT: begin
        cnt_d = cnt_q - c_one;
        if (cnt_q <= c_one) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pending / drop bookkeeping runs every cycle, stalled or not, so a
  // request seen during a stall is never silently lost.
`ifdef INT_PEND_LATCH_EN
  logic w_vec_clear;
  logic w_pend_keep;
  assign w_vec_clear = (state_q == VEC) && !bus.stall;
  assign w_pend_keep = pending_q && !w_vec_clear;
  always_comb begin
    pending_d = w_pend_keep || w_req_busy;
    dropped_d = w_pend_keep && w_req_busy;
  end
`else
  always_comb begin
    pending_d = 1'b0;
    dropped_d = w_req_busy;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ldm_q     <= 1'b0;
      pending_q <= 1'b0;
      dropped_q <= 1'b0;
      out_q     <= '0;
    end else begin
      pending_q <= pending_d;
      dropped_q <= dropped_d;
      if (!bus.stall) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        ldm_q   <= ldm_d;
        out_q   <= seq_outputs(state_d, ldm_d);
      end
    end
  end

  assign bus.inj_valid   = out_q.inj_valid;
  assign bus.inj_op      = OP_W'(out_q.inj_op);
  assign bus.pc_hold     = out_q.pc_hold;
  assign bus.load_vector = out_q.load_vector;
  assign bus.int_ack     = out_q.int_ack;
  assign bus.int_dropped = dropped_q;
  assign bus.busy        = out_q.busy;

endmodule

`default_nettype wire

// File: tb/tb_int_op_sequencer.sv
// ============================================================================
// Module      : tb_int_op_sequencer
// Description : Self-checking bench for int_op_sequencer. A script-based
//               reference model (one queue of expected output slots per
//               sequence) is compared with the DUT every cycle; directed
//               scenarios add literal expectations. Honours
//               INT_PEND_LATCH_EN in the same way as the design.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_int_op_sequencer;

  localparam int D = 2;

  localparam bit [4:0] NOP = 5'b00000, LDM = 5'b10010, RET = 5'b11101, RTI = 5'b11110;
  localparam bit [4:0] PFL = 5'b11111, PPL = 5'b10101, PPH = 5'b10110;
  localparam bit [4:0] OPL = 5'b10111, OPF = 5'b01111, ADD = 5'b01001;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int_op_sequencer_if #(.OP_W(5)) bus ();

  int_op_sequencer #(.OP_W(5), .DRAIN_CYCLES(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    bit       v;
    bit [4:0] op;
    bit       hold;
    bit       lv;
    bit       ack;
  } slot_t;

  slot_t q[$];
  slot_t cur      = '0;
  bit    cur_act  = 1'b0;
  bit    pend     = 1'b0;
  bit    exp_drop = 1'b0;

  function automatic slot_t mk(bit v, bit [4:0] op, bit hold, bit lv, bit ack);
    slot_t s;
    s.v = v; s.op = op; s.hold = hold; s.lv = lv; s.ack = ack;
    return s;
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        q.delete();
        cur_act  = 1'b0;
        cur      = '0;
        pend     = 1'b0;
        exp_drop = 1'b0;
      end else begin
        bit req, fv, st, ret_hit, rti_hit, req_busy, vec_done, pend_after, start;
        bit [4:0] fo;
        req = bus.int_req; fv = bus.fetched_valid; fo = bus.fetched_op; st = bus.stall;
        ret_hit  = !cur_act && fv && (fo == RET);
        rti_hit  = !cur_act && fv && (fo == RTI);
        req_busy = req && (st || cur_act || ret_hit || rti_hit);
        start    = !cur_act && !st && !ret_hit && !rti_hit && (req || pend);
        vec_done = cur_act && cur.ack && !st;
        pend_after = pend && !vec_done;
`ifdef INT_PEND_LATCH_EN
        exp_drop = req_busy && pend_after;
        pend     = pend_after || req_busy;
`else
        exp_drop = req_busy;
        pend     = 1'b0;
`endif
        if (!st) begin
          if (cur_act) begin
            if (q.size() > 0) cur = q.pop_front();
            else begin cur_act = 1'b0; cur = '0; end
          end else if (ret_hit || rti_hit || start) begin
            if (ret_hit || rti_hit) begin
              q.push_back(mk(1, OPL, 1, 0, 0));
              if (rti_hit) q.push_back(mk(1, OPF, 1, 0, 0));
              for (int i = 0; i < D; i++) q.push_back(mk(1, NOP, 1, 0, 0));
            end else begin
              if (fo == LDM) q.push_back(mk(0, NOP, 0, 0, 0));
              for (int i = 0; i < D; i++) q.push_back(mk(1, NOP, 1, 0, 0));
              q.push_back(mk(1, PFL, 1, 0, 0));
              q.push_back(mk(1, PPL, 1, 0, 0));
              q.push_back(mk(1, PPH, 1, 0, 0));
              q.push_back(mk(1, NOP, 1, 1, 1));
            end
            cur     = q.pop_front();
            cur_act = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      check("m_inj_valid",   bus.inj_valid,   cur_act ? cur.v    : 1'b0);
      check("m_inj_op",      bus.inj_op,      cur_act ? cur.op   : 5'd0);
      check("m_pc_hold",     bus.pc_hold,     cur_act ? cur.hold : 1'b0);
      check("m_load_vector", bus.load_vector, cur_act ? cur.lv   : 1'b0);
      check("m_int_ack",     bus.int_ack,     cur_act ? cur.ack  : 1'b0);
      check("m_busy",        bus.busy,        cur_act);
      check("m_int_dropped", bus.int_dropped, exp_drop);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(bit req, bit fv, bit [4:0] fo, bit st);
    bus.int_req       = req;
    bus.fetched_valid = fv;
    bus.fetched_op    = fo;
    bus.stall         = st;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (!bus.busy && !cur_act && !pend) done = 1'b1;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL idle_timeout: busy=%0b still set after 60 cycles", bus.busy);
    end
    repeat (2) @(negedge clk);
  endtask

  logic [4:0] ops [1:20];
  logic       vl  [1:20];
  logic       hl  [1:20];
  logic       lvs [1:20];
  logic       aks [1:20];
  logic       dps [1:20];
  logic       bs  [1:20];

  // Drives the trigger on cycle 0 (already at a negedge), idles inputs
  // afterwards and records outputs seen on cycles 1..n.
  task automatic run_rec(bit req, bit fv, bit [4:0] fo, int n);
    drive(req, fv, fo, 0);
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      if (c == 1) drive(0, 0, NOP, 0);
      ops[c] = bus.inj_op; vl[c] = bus.inj_valid; hl[c] = bus.pc_hold;
      lvs[c] = bus.load_vector; aks[c] = bus.int_ack; dps[c] = bus.int_dropped;
      bs[c]  = bus.busy;
    end
  endtask

  initial begin
    logic [4:0] exp_int [1:6];
    logic [4:0] exp_rti [1:4];
    int pushes, drops;
    exp_int = '{NOP, NOP, PFL, PPL, PPH, NOP};
    exp_rti = '{OPL, OPF, NOP, NOP};

    reset = 1'b1;
    drive(0, 0, NOP, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // idle after reset
    repeat (10) @(negedge clk);
    check("idle_busy", bus.busy, 0);
    check("idle_inj_valid", bus.inj_valid, 0);
    check("idle_pc_hold", bus.pc_hold, 0);

    // interrupt entry, ordinary fetched opcode
    run_rec(1, 1, ADD, 6);
    for (int c = 1; c <= 6; c++) begin
      check($sformatf("int_op_c%0d", c), ops[c], exp_int[c]);
      check($sformatf("int_hold_c%0d", c), hl[c], 1);
      check($sformatf("int_lv_c%0d", c), lvs[c], (c == 6));
      check($sformatf("int_ack_c%0d", c), aks[c], (c == 6));
    end
    wait_idle();

    // interrupt entry with LDM in flight
    run_rec(1, 1, LDM, 6);
    check("ldm_gap_valid", vl[1], 0);
    check("ldm_gap_hold", hl[1], 0);
    check("ldm_gap_busy", bs[1], 1);
    check("ldm_nop_c2", {vl[2], ops[2]}, {1'b1, NOP});
    check("ldm_pushflg_c4", ops[4], PFL);
    check("ldm_ack_c7_pending", aks[6], 0);
    wait_idle();

    // RTI
    run_rec(0, 1, RTI, 5);
    for (int c = 1; c <= 4; c++) begin
      check($sformatf("rti_op_c%0d", c), ops[c], exp_rti[c]);
      check($sformatf("rti_hold_c%0d", c), hl[c], 1);
    end
    check("rti_done", bs[5], 0);
    wait_idle();

    // RET
    run_rec(0, 1, RET, 4);
    check("ret_op_c1", ops[1], OPL);
    check("ret_op_c2", {vl[2], hl[2], ops[2]}, {2'b11, NOP});
    check("ret_op_c3", {vl[3], hl[3], ops[3]}, {2'b11, NOP});
    check("ret_done", bs[4], 0);
    wait_idle();

    // interrupt together with RET
    run_rec(1, 1, RET, 20);
    pushes = 0; drops = 0;
    for (int c = 1; c <= 20; c++) begin
      if (vl[c] && ops[c] == PFL) pushes++;
      if (dps[c]) drops++;
    end
`ifdef INT_PEND_LATCH_EN
    check("retint_pushes", pushes, 1);
    check("retint_drops", drops, 0);
`else
    check("retint_drop_c1", dps[1], 1);
    check("retint_drops", drops, 1);
    check("retint_pushes", pushes, 0);
`endif
    wait_idle();

    // stall during PUSH_PCL
    drive(1, 1, ADD, 0);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) drive(0, 0, NOP, 0);
      if (c >= 4 && c <= 7) check($sformatf("stall_op_c%0d", c), bus.inj_op, PPL);
      if (c == 4) bus.stall = 1'b1;
      if (c == 7) bus.stall = 1'b0;
      if (c == 8) check("stall_release_op", bus.inj_op, PPH);
    end
    wait_idle();

    // asynchronous reset during PUSH_PCL
    drive(1, 1, ADD, 0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) drive(0, 0, NOP, 0);
    end
    check("rst_pre_op", bus.inj_op, PPL);
    #2 reset = 1'b1;
    #1;
    check("rst_async_outputs",
          {bus.inj_valid, bus.inj_op, bus.pc_hold, bus.load_vector, bus.int_ack, bus.int_dropped, bus.busy}, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_after_busy", bus.busy, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      bit [4:0] op;
      r  = $urandom_range(0, 9);
      op = (r == 0) ? RET : (r == 1) ? RTI : (r == 2) ? LDM : 5'($urandom_range(0, 31));
      drive($urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)), op, $urandom_range(0, 5) == 0);
      if (i == 1500) begin
        #3 reset = 1'b1;
        #1 reset = 1'b0;
      end
      @(negedge clk);
    end
    drive(0, 0, NOP, 0);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
